// File: rtl/ld_fifo_if.sv
//------------------------------------------------------------------------------
// Module      : ld_fifo_if
// Description : Bus bundle between the UART receive shifter / host side and
//               the ld_fifo load buffer. The master modport is the user side
//               (drives strobes and write data), the slave modport is the FIFO.
//               Optional macro LD_FIFO_AFULL_EN adds the afull flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ld_fifo_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);

  // Writer / reader strobes and write data
  logic             load;
  logic [WIDTH-1:0] D;
  logic             rd;
  logic             clr_ovf;

  // Holding register and status
  logic [WIDTH-1:0] Q;
  logic             q_valid;
  logic             empty;
  logic             full;
  logic [AW:0]      count;
  logic             ovf;
`ifdef LD_FIFO_AFULL_EN
  logic             afull;
`endif

  // User side: issues strobes, observes data and status
  modport master (
`ifdef LD_FIFO_AFULL_EN
    input  afull,
`endif
    output load, D, rd, clr_ovf,
    input  Q, q_valid, empty, full, count, ovf
  );

  // FIFO side
  modport slave (
`ifdef LD_FIFO_AFULL_EN
    output afull,
`endif
    input  load, D, rd, clr_ovf,
    output Q, q_valid, empty, full, count, ovf
  );

endinterface : ld_fifo_if

`default_nettype wire

// File: rtl/ld_fifo.sv
//------------------------------------------------------------------------------
// Module      : ld_fifo
// Description : DEPTH x WIDTH load buffer between the UART receive shifter and
//               the host. Popped words land in a registered holding output Q
//               one clock after the read strobe. Tracks occupancy, decodes
//               empty/full from the registered count and latches a sticky
//               overrun flag when a word has to be dropped.
//               Optional macro LD_FIFO_AFULL_EN adds afull = (count >= AFULL_THR).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ld_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AW        = 2,
  parameter int AFULL_THR = 3
) (
  input  wire logic  clk,
  input  wire logic  reset,
  ld_fifo_if.slave   bus
);

  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  // Storage (intentionally not reset: contents are only meaningful via count)
  logic [WIDTH-1:0] mem [DEPTH];

  // Registered state and next-state values
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic [WIDTH-1:0] q_q,      q_d;
  logic             q_valid_q, q_valid_d;
  logic             ovf_q,    ovf_d;

  // Acceptance decodes
  logic             empty;
  logic             full;
  logic             wr_ok;
  logic             rd_ok;
  logic             overrun;

  // Flags come from the registered count only, so they cannot glitch on
  // pointer transitions.
  assign empty = (count_q == '0);
  assign full  = (count_q == c_depth);

  // Next-state computation for pointers, count, holding register and ovf
  always_comb begin
    // A full buffer still accepts a write when a read frees a slot in the
    // same cycle; a read of an empty buffer is simply ignored.
    wr_ok     = bus.load & (~full | bus.rd);
    rd_ok     = bus.rd & ~empty;
    overrun   = bus.load & full & ~bus.rd;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    q_d       = q_q;
    q_valid_d = rd_ok;
    ovf_d     = ovf_q;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      q_d      = mem[rd_ptr_q];
    end

    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A new overrun outranks a coincident clear so no loss goes unreported.
    if (overrun) begin
      ovf_d = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // Control and holding-register flops with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage write port; an overrun never reaches here because wr_ok is low
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_q] <= bus.D;
    end
  end

  assign bus.Q       = q_q;
  assign bus.q_valid = q_valid_q;
  assign bus.empty   = empty;
  assign bus.full    = full;
  assign bus.count   = count_q;
  assign bus.ovf     = ovf_q;

`ifdef LD_FIFO_AFULL_EN
  localparam logic [AW:0] c_afull_thr = (AW+1)'(AFULL_THR);

  // Early flow-control hint, decoded from the registered count
  assign bus.afull = (count_q >= c_afull_thr);
`else
  // Threshold only matters when the almost-full flag is built in
  logic unused_afull_thr;
  assign unused_afull_thr = ^32'(AFULL_THR);
`endif

endmodule : ld_fifo

`default_nettype wire

// File: doc/ld_fifo.md
Name: ld_fifo

Overview:
- Parametrised successor to the team's single 8-bit load register.
- Buffers DEPTH words of WIDTH bits between the UART receive shifter (writer, `load`) and the host/bus side (reader, `rd`).
- Popped words are presented on a registered holding output `Q`.
- Adds occupancy tracking, full/empty flags and sticky overrun detection so received bytes are not silently lost.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, number of storage entries; power of 2, minimum 2.
- AW, 2, pointer width; must equal log2(DEPTH).
- AFULL_THR, 3, almost-full threshold in entries; used only with the optional feature; 1..DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  write strobe; pushes D when accepted.
- D  in  WIDTH  write data.
- rd  in  1  read strobe; pops head entry into Q when accepted.
- Q  out  WIDTH  holding register; last popped word.
- q_valid  out  1  one-cycle pulse: Q updated this cycle.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  AW+1  current occupancy, 0..DEPTH.
- ovf  out  1  sticky overrun flag.
- clr_ovf  in  1  synchronous clear of ovf.

Behaviour:
- Reset (async, active-high) forces the following immediately, regardless of clk:
  - read/write pointers = 0, count = 0;
  - Q = 0, q_valid = 0, ovf = 0;
  - empty = 1, full = 0.
- Storage array contents are not reset.
- All state changes occur on the rising edge of clk.
- Write acceptance: wr_ok = load & (!full | rd).
  - On wr_ok, D is stored at wr_ptr.
  - wr_ptr increments modulo DEPTH (natural AW-bit wrap).
- Read acceptance: rd_ok = rd & !empty.
  - On rd_ok, Q <= mem[rd_ptr] and rd_ptr increments modulo DEPTH.
  - q_valid = 1 in the following cycle only.
- Read latency: 1 clock from the rd edge to the new Q. No fall-through: a word loaded in cycle N is poppable from cycle N+1.
- Q holds its value whenever rd_ok = 0.
- count update:
  - +1 on wr_ok & !rd_ok;
  - -1 on rd_ok & !wr_ok;
  - unchanged when both or neither are accepted.
- empty and full are combinational decodes of registered count; no glitch-prone pointer compare.
- Boundary: full & load & rd → both accepted. The oldest word moves to Q, D is written into the freed slot, count stays DEPTH.
- Boundary: empty & load & rd → rd ignored (Q, q_valid unchanged), load accepted, count becomes 1.
- Boundary: empty & rd → no change. Underflow is not flagged.
- Overrun: full & load & !rd → D dropped, array, pointers and count unchanged, ovf <= 1.
- ovf stays set until clr_ovf. If a new overrun and clr_ovf coincide, set wins and ovf stays 1.
- Reset asserted mid-operation discards all buffered data. After release, the block is fully empty and usable in the next cycle.
- No internal state machine beyond the pointer/count datapath. Legal occupancy states run 0..DEPTH, and transitions are only those listed above.

Optional Feature:
- Macro: LD_FIFO_AFULL_EN.
- Defined:
  - adds output port `afull` (1 bit) = (count >= AFULL_THR);
  - `afull` is registered-derived (decode of count) and is 0 in reset.
  - Intended for early flow control (e.g. RTS deassert).
- Undefined:
  - `afull` port and logic are absent;
  - AFULL_THR is ignored;
  - all other behaviour is identical.

Test Plan:
- Reset then idle 5 cycles → Q=0x00, count=0, empty=1, full=0, ovf=0, q_valid=0.
- Load 0x11, 0x22, 0x33, 0x44 on consecutive cycles → full=1, count=4. Then rd for 4 cycles → Q = 0x11, 0x22, 0x33, 0x44, each one cycle after its rd, with q_valid pulsing each time; empty=1 at end.
- Fill with 0xA0..0xA3, load 0xFF with rd=0 → ovf=1, count=4. Drain → 0xA0..0xA3 only, 0xFF never appears. Pulse clr_ovf → ovf=0.
- Full, load 0x55 with rd=1 → Q=0xA0, count stays 4. Subsequent drain yields 0xA1, 0xA2, 0xA3, 0x55.
- Empty, load 0x7E with rd=1 same cycle → Q unchanged, q_valid=0, count=1. Next rd → Q=0x7E.
- Load 3 words, push 10 more with interleaved rd across a pointer wrap, then assert reset mid-stream → outputs return to reset values immediately, with no clk edge needed. With LD_FIFO_AFULL_EN, AFULL_THR=3: afull=1 exactly while count >= 3.
